// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the up/down counter control stage.
//   mode_e      : operating mode of the control FSM (manual / auto)
//   DIR_UP/DOWN : encoding of the counter direction level (dir_o / dir_i)
//   BTN_*       : bit positions of the buttons inside the internal button vector
// ----------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Button vector layout used by the top level to build the debouncer array.
   localparam int BTN_STEP = 0;
   localparam int BTN_DIR  = 1;
   localparam int BTN_MODE = 2;
   localparam int NUM_BTN  = 3;

   // Width needed to hold the values 0..n-1 (at least 1 bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_ctrl_if
// Bundle between the pushbutton side and the counter side of counter_ctrl.
//   btn_step_i / btn_dir_i / btn_mode_i : raw asynchronous, bouncy buttons
//   enable_o : one-cycle count strobe toward the counter's enable_i
//   dir_o    : count direction toward the counter's dir_i (0 up, 1 down)
//   mode_o   : current mode (0 manual, 1 auto)
// Modports:
//   master : the stimulus side (drives buttons, observes outputs)
//   slave  : the control block (reads buttons, drives outputs)
// ----------------------------------------------------------------------------
interface counter_ctrl_if;
   import counter_pkg::*;

   logic btn_step_i;
   logic btn_dir_i;
   logic btn_mode_i;
   logic enable_o;
   logic dir_o;
   logic mode_o;

   modport master (
      output btn_step_i,
      output btn_dir_i,
      output btn_mode_i,
      input  enable_o,
      input  dir_o,
      input  mode_o
   );

   modport slave (
      input  btn_step_i,
      input  btn_dir_i,
      input  btn_mode_i,
      output enable_o,
      output dir_o,
      output mode_o
   );

endinterface

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One pushbutton conditioner: 2-flop synchronizer, debounce counter and a
// registered rise pulse.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_i   : raw asynchronous button
//   level_o : debounced button level
//   press_o : one-cycle pulse on a debounced 0->1 transition
// The debounced level follows the synchronized input only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles; one cycle of agreement
// restarts the count. press_o is raised on the same edge the level rises, so
// from the raw edge k the pulse is visible after edge k+DEBOUNCE_CYCLES+1.
// ----------------------------------------------------------------------------
module btn_debounce
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int                CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= btn_i;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_press <= r_sync2;   // pulse only on the rising change
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign level_o = r_level;
   assign press_o = r_press;

endmodule

// File: rtl/counter_ctrl.sv
// ----------------------------------------------------------------------------
// counter_ctrl
// Upstream control stage for the up/down counter.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : counter_ctrl_if.slave
//            btn_step_i, btn_dir_i, btn_mode_i : raw buttons
//            enable_o : count strobe, dir_o : direction, mode_o : mode
// Three debouncers turn the buttons into press pulses. A dir press toggles
// dir_o. The mode FSM toggles between MANUAL (each step press is one strobe)
// and AUTO (a prescaler strobes once every PRESCALE cycles, step ignored).
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PRESCALE        = 8
) (
   input  logic           clk,
   input  logic           rst,
   counter_ctrl_if.slave  bus
);

   localparam int            PW      = cnt_width(PRESCALE);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   logic [NUM_BTN-1:0] w_btn;
   logic [NUM_BTN-1:0] w_level;
   logic [NUM_BTN-1:0] w_press;
   logic               w_unused_levels;

   mode_e         r_state;
   logic          r_enable;
   logic          r_dir;
   logic [PW-1:0] r_presc;

   assign w_btn[BTN_STEP] = bus.btn_step_i;
   assign w_btn[BTN_DIR]  = bus.btn_dir_i;
   assign w_btn[BTN_MODE] = bus.btn_mode_i;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_btn (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (w_btn[gi]),
            .level_o (w_level[gi]),
            .press_o (w_press[gi])
         );
      end
   endgenerate

   // Debounced levels are only of interest to observers of the hierarchy.
   assign w_unused_levels = ^w_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= MODE_MANUAL;
         r_enable <= 1'b0;
         r_dir    <= DIR_UP;
         r_presc  <= '0;
      end else begin
         // Independent of the mode; in AUTO the prescaler is untouched.
         if (w_press[BTN_DIR]) begin
            r_dir <= ~r_dir;
         end

         r_enable <= 1'b0;
         case (r_state)
            MODE_MANUAL: begin
               if (w_press[BTN_MODE]) begin
                  // Mode change wins over a coincident step press.
                  r_state <= MODE_AUTO;
                  r_presc <= '0;
               end else begin
                  r_enable <= w_press[BTN_STEP];
               end
            end
            MODE_AUTO: begin
               if (w_press[BTN_MODE]) begin
                  r_state <= MODE_MANUAL;
                  r_presc <= '0;
               end else begin
                  // Strobe is registered off the terminal count, so the
                  // first strobe lands PRESCALE cycles after entering AUTO.
                  r_enable <= (r_presc == PS_LAST);
                  r_presc  <= (r_presc == PS_LAST) ? '0 : r_presc + PW'(1);
               end
            end
            default: begin
               r_state <= MODE_MANUAL;
               r_presc <= '0;
            end
         endcase
      end
   end

   assign bus.enable_o = r_enable;
   assign bus.dir_o    = r_dir;
   assign bus.mode_o   = (r_state == MODE_AUTO);

endmodule

// File: tb/tb_counter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_counter_ctrl
// Directed bench for counter_ctrl with DEBOUNCE_CYCLES=4, PRESCALE=8, so a
// clean press applied before edge 1 shows at the outputs after edge 7.
// ----------------------------------------------------------------------------
module tb_counter_ctrl;
   import counter_pkg::*;

   localparam int DEB = 4;
   localparam int PS  = 8;
   localparam int LAT = DEB + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   counter_ctrl_if bus ();

   counter_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .PRESCALE        (PS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %-16s got=%0h expected=%0h", tag, obs, exp);
      end else begin
         $display("ok   %-16s got=%0h", tag, obs);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_all(input int n);
      bus.btn_step_i = 1'b0;
      bus.btn_dir_i  = 1'b0;
      bus.btn_mode_i = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Run n edges, counting enable_o strobes and the first edge seen high.
   task automatic run_en(input int n, output int cnt, output int first);
      cnt   = 0;
      first = 0;
      for (int e = 1; e <= n; e++) begin
         tick();
         if (bus.enable_o === 1'b1) begin
            cnt++;
            if (first == 0) first = e;
         end
      end
   endtask

   initial begin
      int cnt;
      int first;
      int bad;
      int pat [5];
      logic [31:0] mask;
      logic [31:0] exp_mask;

      bus.btn_step_i = 1'b0;
      bus.btn_dir_i  = 1'b0;
      bus.btn_mode_i = 1'b0;

      // ---- reset and idle ----
      rst = 1'b1;
      repeat (3) tick();
      check("rst_enable", {31'd0, bus.enable_o}, 0);
      check("rst_dir",    {31'd0, bus.dir_o},    0);
      check("rst_mode",   {31'd0, bus.mode_o},   0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.enable_o !== 1'b0 || bus.dir_o !== 1'b0 || bus.mode_o !== 1'b0) bad++;
      end
      check("idle_outputs", bad, 0);

      // ---- clean step press held 30 cycles ----
      bus.btn_step_i = 1'b1;
      run_en(30, cnt, first);
      check("clean_cnt",   cnt,   1);
      check("clean_edge",  first, LAT);
      bus.btn_step_i = 1'b0;
      run_en(20, cnt, first);
      check("release_cnt", cnt, 0);

      // ---- bouncy press: 1,0,1,1,0 then solid 1 from edge 6 ----
      pat = '{1, 0, 1, 1, 0};
      cnt = 0;
      first = 0;
      for (int e = 1; e <= 40; e++) begin
         bus.btn_step_i = (e <= 5) ? pat[e-1][0] : 1'b1;
         tick();
         if (bus.enable_o === 1'b1) begin
            cnt++;
            if (first == 0) first = e;
         end
      end
      check("bounce_cnt",  cnt,   1);
      check("bounce_edge", first, 6 + LAT - 1);
      release_all(20);

      // ---- 3-cycle glitch ----
      bus.btn_step_i = 1'b1;
      run_en(3, cnt, first);
      bus.btn_step_i = 1'b0;
      run_en(20, first, bad);
      check("glitch_cnt", cnt + first, 0);

      // ---- dir press twice ----
      bus.btn_dir_i = 1'b1;
      first = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (bus.dir_o === 1'b1 && first == 0) first = e;
      end
      check("dir_rise_edge", first, LAT);
      release_all(20);
      check("dir_held_1", {31'd0, bus.dir_o}, 1);
      bus.btn_dir_i = 1'b1;
      first = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (bus.dir_o === 1'b0 && first == 0) first = e;
      end
      check("dir_fall_edge", first, LAT);
      release_all(20);

      // ---- dir and step on the same cycle ----
      bus.btn_dir_i  = 1'b1;
      bus.btn_step_i = 1'b1;
      repeat (LAT - 1) tick();
      check("both_pre_dir", {31'd0, bus.dir_o},    0);
      check("both_pre_en",  {31'd0, bus.enable_o}, 0);
      tick();
      check("both_dir",     {31'd0, bus.dir_o},    1);
      check("both_en",      {31'd0, bus.enable_o}, 1);
      tick();
      check("both_en_after", {31'd0, bus.enable_o}, 0);
      release_all(20);

      // ---- enter AUTO (dir_o is 1 here) ----
      bus.btn_mode_i = 1'b1;
      repeat (LAT - 1) tick();
      check("mode_pre",  {31'd0, bus.mode_o}, 0);
      tick();
      check("mode_auto", {31'd0, bus.mode_o}, 1);
      bus.btn_mode_i = 1'b0;
      // Step and dir presses inside the window must not alter the strobe train.
      mask = '0;
      exp_mask = '0;
      exp_mask[8]  = 1'b1;
      exp_mask[16] = 1'b1;
      exp_mask[24] = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         if (e == 2)  bus.btn_step_i = 1'b1;
         if (e == 12) bus.btn_step_i = 1'b0;
         if (e == 3)  bus.btn_dir_i  = 1'b1;
         if (e == 15) bus.btn_dir_i  = 1'b0;
         tick();
         if (bus.enable_o === 1'b1) mask[e] = 1'b1;
      end
      check("auto_strobes", mask, exp_mask);
      check("auto_dir",     {31'd0, bus.dir_o}, 0);
      release_all(20);

      // ---- back to MANUAL: strobes stop ----
      bus.btn_mode_i = 1'b1;
      repeat (LAT - 1) tick();
      check("mode_pre2",   {31'd0, bus.mode_o}, 1);
      tick();
      check("mode_manual", {31'd0, bus.mode_o},   0);
      check("mode_sw_en",  {31'd0, bus.enable_o}, 0);
      bus.btn_mode_i = 1'b0;
      run_en(30, cnt, first);
      check("manual_quiet", cnt, 0);

      // ---- mode and step together: mode wins ----
      bus.btn_mode_i = 1'b1;
      bus.btn_step_i = 1'b1;
      repeat (LAT - 1) tick();
      check("ms_pre_mode", {31'd0, bus.mode_o}, 0);
      tick();
      check("ms_mode",     {31'd0, bus.mode_o},   1);
      check("ms_en",       {31'd0, bus.enable_o}, 0);
      tick();
      check("ms_en_next",  {31'd0, bus.enable_o}, 0);
      release_all(20);

      // ---- reset in the cycle a dir press would land (AUTO, dir_o=0) ----
      bus.btn_dir_i = 1'b1;
      repeat (LAT - 2) tick();
      rst = 1'b1;
      tick();
      check("rst_mid_en",   {31'd0, bus.enable_o}, 0);
      check("rst_mid_mode", {31'd0, bus.mode_o},   0);
      check("rst_mid_dir",  {31'd0, bus.dir_o},    0);
      rst = 1'b0;
      // Button still held: a fresh press completes LAT edges after reset drops.
      tick();
      check("rst_no_press", {31'd0, bus.dir_o}, 0);
      repeat (LAT - 2) tick();
      check("rst_pre_dir",  {31'd0, bus.dir_o}, 0);
      tick();
      check("rst_re_dir",   {31'd0, bus.dir_o}, 1);
      release_all(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Upstream control stage for the up/down counter. Conditions three raw pushbuttons (step, direction, mode) with synchronization, debounce and rising-edge detection. Produces the counter's enable_i strobe and dir_i level. In manual mode one button press gives one count. In auto mode a prescaler issues a periodic count strobe.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a button level change (>=2)
PRESCALE, 8, auto-mode strobe period in clk cycles (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
btn_step_i  input  1  raw step button, asynchronous, bouncy
btn_dir_i  input  1  raw direction button, asynchronous, bouncy
btn_mode_i  input  1  raw mode button, asynchronous, bouncy
enable_o  output  1  one-cycle count strobe, drives counter enable_i
dir_o  output  1  count direction (0 up, 1 down), drives counter dir_i
mode_o  output  1  current mode (0 manual, 1 auto)

Behaviour:
- Reset (sync, active-high, sampled each rising clk edge): enable_o=0, dir_o=0, mode_o=0 (MANUAL). All synchronizer flops, debounced levels, debounce counters and the prescaler clear to 0. Reset overrides any press occurring in the same cycle.
- Per button: 2-flop synchronizer, then debounce.
  - Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle of agreement clears the debounce counter.
- Press pulse: 1 cycle, registered, on a 0->1 transition of the debounced level only.
  - Holding the button gives no further pulses.
  - Release gives no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES give nothing.
- Latency: a clean 0->1 input step applied before edge k produces a press effect visible at the outputs after edge k+DEBOUNCE_CYCLES+2. That is L = DEBOUNCE_CYCLES+3 edges counting edge k. The figure is fixed and must be exact.
- dir_o: toggles on each dir press pulse, registered.
- Mode FSM states: MANUAL, AUTO. A mode press pulse toggles the state, and mode_o reflects it.
- MANUAL: enable_o = step press pulse (exactly one cycle high per press).
- AUTO:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - enable_o is high for the single cycle in which the prescaler equals PRESCALE-1.
  - Step presses are ignored.
- Entering either state clears the prescaler to 0. The first auto strobe therefore occurs PRESCALE cycles after mode_o rises.
- Simultaneous events:
  - Dir and step press pulses in the same cycle: dir_o toggles and enable_o pulses on the same edge, so the counter steps in the new direction.
  - A mode press in the same cycle as a step press: the mode change wins and enable_o stays 0 in that cycle.
  - A dir press in AUTO toggles dir_o without disturbing the prescaler.
- enable_o is never high for two consecutive cycles in MANUAL.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {MODE_MANUAL=1'b0, MODE_AUTO=1'b1} mode_e
  - localparam DIR_UP=1'b0, DIR_DOWN=1'b1, shared with the counter and its bench
- Sub-module btn_debounce:
  - Contains the synchronizer, debounce counter and rise-pulse register.
  - Parameter DEBOUNCE_CYCLES. Ports clk, rst, btn_i, level_o, press_o.
  - Instantiated three times.
- Top-level counter_ctrl holds the mode FSM, prescaler and dir toggle.

Test Plan (DEBOUNCE_CYCLES=4, PRESCALE=8, L=7):
- Reset, then idle 20 cycles -> enable_o=0, dir_o=0, mode_o=0 throughout; assert rst mid-press -> all outputs 0 on the following edge.
- Clean step press held 30 cycles in MANUAL -> enable_o high for exactly 1 cycle, at edge L=7 after the input rise; release -> no pulse.
- Bouncy step press (pattern 1,0,1,1,0 each 1 cycle, then solid 1) -> exactly one enable_o pulse, 7 edges after the solid level begins; a 3-cycle glitch alone -> no pulse.
- Dir press twice -> dir_o 0->1 at edge 7, then 1->0 after the second press; dir and step pressed on the same cycle -> dir_o=1 and enable_o=1 on the same edge.
- Mode press -> mode_o=1; enable_o pulses on cycles 8, 16, 24 after mode_o rises (period 8); step presses in AUTO produce no extra pulses.
- Mode press again -> mode_o=0 and auto strobes stop; mode and step pressed together -> mode toggles and enable_o stays 0 that cycle.
